mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum BUSY cycles waiting for mem_ack before abort (range 1..255).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 req  input  3  request vector; bit0 = instruction fetch, bit1 = data load, bit2 = data store.
REQ-005 mem_ack  input  1  memory completion strobe, one cycle.
REQ-006 sel_first  output  1  steers the 12-bit address mux and 8-bit data mux to requester 0.
REQ-007 sel_second  output  1  steers the muxes to requester 1.
REQ-008 sel_third  output  1  steers the muxes to requester 2.
REQ-009 mem_req  output  1  memory access strobe, held for the whole transaction.
REQ-010 mem_we  output  1  write enable; high only when requester 2 is granted.
REQ-011 done  output  3  one-cycle completion pulse to the granted requester.
REQ-012 err  output  1  one-cycle pulse coincident with done when the transaction timed out.

Function
REQ-013 The block SHALL implement FSM states IDLE, BUSY and DONE.
REQ-014 IDLE: if req != 0, SHALL register grant via round-robin, highest priority starting at (last_grant+1) mod 3, and go to BUSY; otherwise stay IDLE.
REQ-015 BUSY: SHALL drive mem_req=1, the granted select one-hot, mem_we=grant==2, and increment a wait counter each cycle.
REQ-016 BUSY with mem_ack=1 SHALL go to DONE with err=0 next cycle.
REQ-017 BUSY with counter==TIMEOUT-1 and mem_ack=0 SHALL go to DONE with err=1; simultaneous mem_ack and timeout SHALL count as success.
REQ-018 DONE: SHALL assert done[grant] for one cycle, keep the select asserted, drive mem_req=0, update last_grant=grant, and go to IDLE.
REQ-019 Selects SHALL be one-hot in BUSY and DONE and all zero in IDLE; the select SHALL never change between BUSY entry and DONE exit.
REQ-020 Latency: req seen in IDLE at cycle t -> mem_req at t+1; mem_ack at cycle a -> done at a+1 -> IDLE at a+2; earliest next mem_req at a+3.
REQ-021 Deasserting req during BUSY SHALL NOT abort the transaction; done still pulses.
REQ-022 mem_ack in IDLE or DONE SHALL be ignored.
REQ-023 The wait counter SHALL be cleared on BUSY entry; width ceil(log2(TIMEOUT+1)), no wrap within TIMEOUT.
REQ-024 A requester holding req continuously SHALL be granted at most once before each other active requester is granted (no starvation).

Reset
REQ-025 rst=1 at a clock edge SHALL force state IDLE, last_grant=2, counter=0 and grant=0 from any state, including mid-BUSY, discarding the transaction without a done pulse.
REQ-026 During and after reset all outputs SHALL be 0 (sel_first, sel_second, sel_third, mem_req, mem_we, done, err).

Structure
REQ-027 Package mem_arb_pkg SHALL hold the state enum, requester index constants (REQ_FETCH=0, REQ_LOAD=1, REQ_STORE=2) and the TIMEOUT default.
REQ-028 Round-robin selection SHALL reside in one combinational sub-module rr_picker (inputs req, last_grant; outputs grant index, valid).
REQ-029 Outputs SHALL be decoded from registered state and grant only, with no combinational path from req or mem_ack to outputs.

Verification
REQ-030 Reset, then req=3'b111 held, mem_ack 2 cycles after each mem_req -> grant order 0,1,2,0; done=001,010,100,001.
REQ-031 req=3'b100 only, ack after 3 cycles -> mem_we=1 and sel_third=1 for 4 BUSY cycles plus DONE; done=100, err=0.
REQ-032 req=3'b010, no mem_ack, TIMEOUT=15 -> mem_req high exactly 15 cycles, then done=010 with err=1.
REQ-033 rst pulsed during BUSY of requester 1 -> next cycle all outputs 0; with req=3'b111, the next grant is requester 0.
REQ-034 mem_ack coincident with the final timeout cycle -> err=0; a stray mem_ack in IDLE -> no state change.
REQ-035 Random req/ack for 10k cycles -> selects one-hot or zero, selects stable across each transaction, one done per grant, no starvation beyond 2 grants.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the three-requester memory arbiter.
// Holds the FSM state type, requester indices and the default abort timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] REQ_FETCH = 2'd0;
  localparam logic [1:0] REQ_LOAD  = 2'd1;
  localparam logic [1:0] REQ_STORE = 2'd2;

  localparam int TIMEOUT_DEFAULT = 15;

  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    onehot3 = 3'b001 << idx;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker over three requesters.
// Priority starts at (last_grant+1) mod 3 and wraps around.
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last_grant,
  output logic [1:0] grant,
  output logic       valid
);

  logic [1:0] pos;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant = REQ_FETCH;
    valid = 1'b0;
    pos   = 2'd0;
    // Walk from lowest to highest priority so the highest-priority hit is written last.
    for (int k = 3; k >= 1; k--) begin
      pos = 2'((int'(last_grant) + k) % 3);
      if (req[pos]) begin
        grant = pos;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter granting one of three requesters a memory transaction,
// with a bounded wait for mem_ack and an error pulse on timeout.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] req,
  input  logic       mem_ack,
  output logic       sel_first,
  output logic       sel_second,
  output logic       sel_third,
  output logic       mem_req,
  output logic       mem_we,
  output logic [2:0] done,
  output logic       err
);

  localparam int             CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  LAST_WAIT = CW'(TIMEOUT - 1);

  state_t        state;
  logic [1:0]    grant;
  logic [1:0]    last_grant;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    sel;
  logic [1:0]    pick;
  logic          pick_valid;

  rr_picker u_picker (
    .req        (req),
    .last_grant (last_grant),
    .grant      (pick),
    .valid      (pick_valid)
  );

  assign sel_first  = sel[0];
  assign sel_second = sel[1];
  assign sel_third  = sel[2];

  // All outputs are registered alongside the state, so req and mem_ack never reach a pin combinationally.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state      <= IDLE;
      grant      <= REQ_FETCH;
      last_grant <= REQ_STORE;
      wait_cnt   <= '0;
      sel        <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      done       <= '0;
      err        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state    <= BUSY;
            grant    <= pick;
            wait_cnt <= '0;
            sel      <= onehot3(pick);
            mem_req  <= 1'b1;
            mem_we   <= (pick == REQ_STORE);
          end
        end
        BUSY: begin
          // An ack on the last allowed cycle still counts as success.
          if (mem_ack || (wait_cnt == LAST_WAIT)) begin
            state   <= DONE;
            mem_req <= 1'b0;
            done    <= onehot3(grant);
            err     <= ~mem_ack;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          last_grant <= grant;
          sel        <= '0;
          mem_we     <= 1'b0;
          done       <= '0;
          err        <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          sel     <= '0;
          mem_req <= 1'b0;
          mem_we  <= 1'b0;
          done    <= '0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-level model compared every
// cycle, plus directed scenarios with hand-computed expectations.
module tb_mem_arbiter;

  localparam int TIMEOUT = 15;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] req;
  logic       mem_ack;
  logic       sel_first, sel_second, sel_third;
  logic       mem_req, mem_we, err;
  logic [2:0] done;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mem_ack    (mem_ack),
    .sel_first  (sel_first),
    .sel_second (sel_second),
    .sel_third  (sel_third),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .done       (done),
    .err        (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 waiting on memory, 2 completing
  int m_ph = 0, m_g = 0, m_last = 2, m_cyc = 0;
  bit m_err = 1'b0;

  function automatic int rr_pick(input logic [2:0] r, input int last);
    for (int k = 1; k <= 3; k++)
      if (((r >> ((last + k) % 3)) & 3'b001) != 3'b000) return (last + k) % 3;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_ph = 0; m_g = 0; m_last = 2; m_cyc = 0; m_err = 1'b0;
    end else if (m_ph == 0) begin
      if (req != 3'b000) begin
        m_g = rr_pick(req, m_last); m_ph = 1; m_cyc = 0;
      end
    end else if (m_ph == 1) begin
      m_cyc++;  // busy cycles spent so far, including this one
      if (mem_ack) begin
        m_ph = 2; m_err = 1'b0;
      end else if (m_cyc == TIMEOUT) begin
        m_ph = 2; m_err = 1'b1;
      end
    end else begin
      m_last = m_g; m_ph = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [2:0] exp_sel;
      exp_sel = (m_ph != 0) ? 3'(1 << m_g) : 3'b000;
      check("sel",     32'({sel_third, sel_second, sel_first}), 32'(exp_sel));
      check("mem_req", 32'(mem_req), 32'(m_ph == 1));
      check("mem_we",  32'(mem_we),  32'(m_ph != 0 && m_g == 2));
      check("done",    32'(done),    32'((m_ph == 2) ? exp_sel : 3'b000));
      check("err",     32'(err),     32'(m_ph == 2 && m_err));
    end
  end

  // ---------------- transaction monitor (DUT observation) ----------------
  int         run = 0, we_run = 0, last_run = 0, last_we_run = 0;
  logic [2:0] last_done = '0;
  logic       last_err = 1'b0, done_sel3 = 1'b0, done_we = 1'b0;
  logic [2:0] done_q[$];

  always @(negedge clk) begin
    if (rst) begin
      run = 0; we_run = 0;
    end else begin
      if (mem_req) begin
        run++;
        if (mem_we && sel_third) we_run++;
      end
      if (done != 3'b000) begin
        last_run = run; last_we_run = we_run; last_done = done; last_err = err;
        done_sel3 = sel_third; done_we = mem_we;
        done_q.push_back(done);
        run = 0; we_run = 0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic wait_mem_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (mem_req) begin ok = 1'b1; return; end
    end
    checks++; errors++;
    $display("FAIL wait_mem_req: got no mem_req within 40 cycles, want mem_req=1");
  endtask

  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done != 3'b000) return;
      step();
    end
    checks++; errors++;
    $display("FAIL wait_done: got no done within 40 cycles, want done pulse");
  endtask

  // d >= 0: ack raised d cycles after mem_req is first seen; d < 0: never ack.
  task automatic do_txn(input logic [2:0] r, input int d, input bit hold);
    bit ok;
    req = r;
    wait_mem_req(ok);
    if (!ok) return;
    if (d >= 0) begin
      repeat (d) step();
      mem_ack = 1'b1;
      step();
      mem_ack = 1'b0;
    end
    wait_done();
    if (!hold) req = 3'b000;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, want bench to finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;
    rst = 1'b1; req = 3'b000; mem_ack = 1'b0;
    repeat (2) step();
    chk_en = 1'b1;
    check("reset_outputs", 32'({sel_first, sel_second, sel_third, mem_req, mem_we, done, err}), 32'd0);
    rst = 1'b0;
    step();

    // Round robin with all requesters active
    done_q.delete();
    repeat (4) do_txn(3'b111, 2, 1'b1);
    req = 3'b000;
    step();
    check("rr_count", 32'(done_q.size()), 32'd4);
    check("rr_done0", 32'(done_q[0]), 32'h1);
    check("rr_done1", 32'(done_q[1]), 32'h2);
    check("rr_done2", 32'(done_q[2]), 32'h4);
    check("rr_done3", 32'(done_q[3]), 32'h1);
    check("model_last_grant", 32'(m_last), 32'd0);

    // Store: write enable and third select through busy and done
    do_txn(3'b100, 3, 1'b0);
    check("store_busy_cycles", 32'(last_run), 32'd4);
    check("store_we_sel_cycles", 32'(last_we_run), 32'd4);
    check("store_done", 32'(last_done), 32'h4);
    check("store_err", 32'(last_err), 32'd0);
    check("store_done_sel3", 32'(done_sel3), 32'd1);
    check("store_done_we", 32'(done_we), 32'd1);
    step();

    // Load with no ack times out
    do_txn(3'b010, -1, 1'b0);
    check("timeout_busy_cycles", 32'(last_run), 32'd15);
    check("timeout_done", 32'(last_done), 32'h2);
    check("timeout_err", 32'(last_err), 32'd1);
    step();

    // Reset in the middle of a load transaction
    req = 3'b010;
    wait_mem_req(ok);
    step();
    rst = 1'b1;
    step();
    check("midbusy_reset_outputs", 32'({sel_first, sel_second, sel_third, mem_req, mem_we, done, err}), 32'd0);
    n = done_q.size();
    rst = 1'b0;
    req = 3'b111;
    wait_mem_req(ok);
    check("post_reset_grant", 32'({sel_third, sel_second, sel_first}), 32'h1);
    check("no_done_on_reset", 32'(done_q.size()), 32'(n));
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    wait_done();
    req = 3'b000;
    step();

    // Ack on the final allowed cycle is a success
    do_txn(3'b001, 14, 1'b0);
    check("edge_ack_busy_cycles", 32'(last_run), 32'd15);
    check("edge_ack_done", 32'(last_done), 32'h1);
    check("edge_ack_err", 32'(last_err), 32'd0);
    step();

    // Stray ack while idle
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("stray_ack_mem_req", 32'(mem_req), 32'd0);
      check("stray_ack_done", 32'(done), 32'd0);
      step();
    end

    // Random traffic, checked every cycle against the model
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
      mem_ack = ($urandom_range(0, 7) == 0);
      step();
    end
    req = 3'b000; mem_ack = 1'b0;
    repeat (25) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
